// File: rtl/fixed_to_ascii_formatter.sv
// Signed fixed-point to packed ASCII decimal ("sIII.FFFF") formatter.
// Serial conversion: double-dabble over the integer field, then repeated x10 over the fraction.
module fixed_to_ascii_formatter #(
    parameter int INT_BITS    = 3,
    parameter int FRAC_BITS   = 30,
    parameter int INT_DIGITS  = 1,
    parameter int FRAC_DIGITS = 4,
    parameter int TAG_W       = 2,
    parameter int LEAD_BLANK  = 1,
    localparam int BITS       = INT_BITS + FRAC_BITS,
    localparam int NUM_CHARS  = INT_DIGITS + FRAC_DIGITS + 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [BITS-1:0]        i_value,
    input  logic [TAG_W-1:0]       i_tag,
    output logic                   o_valid,
    output logic [NUM_CHARS*8-1:0] o_chars,
    output logic [TAG_W-1:0]       o_tag,
    output logic                   o_overflow
);

    localparam int BCD_W = INT_DIGITS * 4;
    localparam int FD_W  = FRAC_DIGITS * 4;
    localparam int PW    = FRAC_BITS + 4;
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_INT,
        S_FRAC,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic                   sign_q, sign_d;
    logic [INT_BITS-1:0]    intSh_q, intSh_d;
    logic [FRAC_BITS-1:0]   frac_q, frac_d;
    logic [BCD_W-1:0]       bcd_q, bcd_d;
    logic [FD_W-1:0]        fdig_q, fdig_d;
    logic                   ovf_q, ovf_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [TAG_W-1:0]       tag_q, tag_d;
    logic [NUM_CHARS*8-1:0] chars_q, chars_d;
    logic [TAG_W-1:0]       tagOut_q, tagOut_d;
    logic                   ovfOut_q, ovfOut_d;
    logic                   valid_q, valid_d;

    logic [BITS-1:0]        mag;
    logic [BCD_W-1:0]       bcdAdj;
    logic [PW-1:0]          prod;
    logic [NUM_CHARS*8-1:0] charsFmt;
    logic                   blanking;

    // Two's complement negate as unsigned: the most negative input maps to 2^(BITS-1) exactly.
    assign mag = i_value[BITS-1] ? (~i_value + BITS'(1)) : i_value;

    always_comb begin
        bcdAdj = bcd_q;
        for (int d = 0; d < INT_DIGITS; d++) begin
            if (bcd_q[d*4 +: 4] >= 4'd5) begin
                bcdAdj[d*4 +: 4] = bcd_q[d*4 +: 4] + 4'd3;
            end
        end
        prod = {4'b0000, frac_q} * PW'(10);
    end

    // Character k counts from the right: fraction digits, '.', integer digits, sign.
    always_comb begin
        charsFmt = {NUM_CHARS{8'h20}};
        blanking = (LEAD_BLANK != 0);
        for (int k = 0; k < FRAC_DIGITS; k++) begin
            charsFmt[k*8 +: 8] = ovf_q ? 8'h23 : (8'h30 + {4'h0, fdig_q[k*4 +: 4]});
        end
        charsFmt[FRAC_DIGITS*8 +: 8] = 8'h2E;
        for (int i = INT_DIGITS - 1; i >= 0; i--) begin
            if (bcd_q[i*4 +: 4] != 4'h0 || i == 0) begin
                blanking = 1'b0;
            end
            if (ovf_q) begin
                charsFmt[(FRAC_DIGITS+1+i)*8 +: 8] = 8'h23;
            end else if (blanking) begin
                charsFmt[(FRAC_DIGITS+1+i)*8 +: 8] = 8'h20;
            end else begin
                charsFmt[(FRAC_DIGITS+1+i)*8 +: 8] = 8'h30 + {4'h0, bcd_q[i*4 +: 4]};
            end
        end
        charsFmt[(NUM_CHARS-1)*8 +: 8] = sign_q ? 8'h2D : 8'h20;
    end

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        intSh_d  = intSh_q;
        frac_d   = frac_q;
        bcd_d    = bcd_q;
        fdig_d   = fdig_q;
        ovf_d    = ovf_q;
        cnt_d    = cnt_q;
        tag_d    = tag_q;
        chars_d  = chars_q;
        tagOut_d = tagOut_q;
        ovfOut_d = ovfOut_q;
        valid_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    sign_d  = i_value[BITS-1];
                    intSh_d = mag[BITS-1:FRAC_BITS];
                    frac_d  = mag[FRAC_BITS-1:0];
                    bcd_d   = '0;
                    fdig_d  = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                    tag_d   = i_tag;
                    state_d = S_INT;
                end
            end
            S_INT: begin
                bcd_d   = {bcdAdj[BCD_W-2:0], intSh_q[INT_BITS-1]};
                ovf_d   = ovf_q | bcdAdj[BCD_W-1];
                intSh_d = intSh_q << 1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(INT_BITS - 1)) begin
                    cnt_d   = '0;
                    state_d = S_FRAC;
                end
            end
            S_FRAC: begin
                fdig_d = (fdig_q << 4) | FD_W'(prod[PW-1:FRAC_BITS]);
                frac_d = prod[FRAC_BITS-1:0];
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(FRAC_DIGITS - 1)) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                chars_d  = charsFmt;
                tagOut_d = tag_q;
                ovfOut_d = ovf_q;
                valid_d  = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            sign_q   <= 1'b0;
            intSh_q  <= '0;
            frac_q   <= '0;
            bcd_q    <= '0;
            fdig_q   <= '0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
            tag_q    <= '0;
            chars_q  <= {NUM_CHARS{8'h20}};
            tagOut_q <= '0;
            ovfOut_q <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            intSh_q  <= intSh_d;
            frac_q   <= frac_d;
            bcd_q    <= bcd_d;
            fdig_q   <= fdig_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
            tag_q    <= tag_d;
            chars_q  <= chars_d;
            tagOut_q <= tagOut_d;
            ovfOut_q <= ovfOut_d;
            valid_q  <= valid_d;
        end
    end

    assign o_ready    = (state_q == S_IDLE);
    assign o_valid    = valid_q;
    assign o_chars    = chars_q;
    assign o_tag      = tagOut_q;
    assign o_overflow = ovfOut_q;

endmodule

// File: tb/tb_fixed_to_ascii_formatter.sv
// Scoreboard bench for fixed_to_ascii_formatter: default Q3.30 instance plus two Q6.30 instances.
module tb_fixed_to_ascii_formatter;

    localparam int N0 = 3 + 4 + 1;
    localparam int N1 = 6 + 4 + 1;

    typedef struct {
        logic [63:0] chars;
        logic [1:0]  tag;
        logic        ovf;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        v0, v1, v2;
    logic [32:0] val0;
    logic [35:0] val1, val2;
    logic [1:0]  tg0, tg1, tg2;
    logic        r0, r1, r2;
    logic        ov0, ov1, ov2;
    logic [55:0] ch0, ch1;
    logic [63:0] ch2;
    logic [1:0]  otg0, otg1, otg2;
    logic        of0, of1, of2;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t q0[$], q1[$], q2[$];
    exp_t e0, e1, e2;
    int   acc;
    int   accFirst;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fixed_to_ascii_formatter dut0 (
        .i_clk(clk), .i_rst(rst), .i_valid(v0), .o_ready(r0), .i_value(val0), .i_tag(tg0),
        .o_valid(ov0), .o_chars(ch0), .o_tag(otg0), .o_overflow(of0)
    );

    fixed_to_ascii_formatter #(.INT_BITS(6), .INT_DIGITS(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_valid(v1), .o_ready(r1), .i_value(val1), .i_tag(tg1),
        .o_valid(ov1), .o_chars(ch1), .o_tag(otg1), .o_overflow(of1)
    );

    fixed_to_ascii_formatter #(.INT_BITS(6), .INT_DIGITS(2), .LEAD_BLANK(1)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_valid(v2), .o_ready(r2), .i_value(val2), .i_tag(tg2),
        .o_valid(ov2), .o_chars(ch2), .o_tag(otg2), .o_overflow(of2)
    );

    task automatic checkOutput(input string name, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", name, obs, expv);
        end
    endtask

    function automatic logic getReady(input int which);
        case (which)
            0:       return r0;
            1:       return r1;
            default: return r2;
        endcase
    endfunction

    task automatic driveInputs(input int which, input logic valid, input logic [35:0] value,
                               input logic [1:0] tag);
        case (which)
            0: begin v0 = valid; val0 = value[32:0]; tg0 = tag; end
            1: begin v1 = valid; val1 = value;       tg1 = tag; end
            default: begin v2 = valid; val2 = value; tg2 = tag; end
        endcase
    endtask

    // Called at a negedge; returns at the negedge right after the accept edge.
    task automatic applyStimulus(input int which, input logic [35:0] value, input logic [1:0] tag,
                                 input logic [63:0] expChars, input logic expOvf,
                                 input bit hold, input bit push, output int acceptCyc);
        bit   accepted = 0;
        logic rdy;
        exp_t e;
        driveInputs(which, 1'b1, value, tag);
        for (int k = 0; k < 200 && !accepted; k++) begin
            rdy = getReady(which);
            @(posedge clk);
            if (rdy) accepted = 1;
            @(negedge clk);
        end
        checkOutput("accept", 64'(accepted), 64'(1));
        acceptCyc = cyc;
        if (!hold) driveInputs(which, 1'b0, ~value, ~tag);
        if (push) begin
            e.chars = expChars;
            e.tag   = tag;
            e.ovf   = expOvf;
            e.cyc   = cyc + ((which == 0) ? N0 : N1);
            case (which)
                0:       q0.push_back(e);
                1:       q1.push_back(e);
                default: q2.push_back(e);
            endcase
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && (q0.size() + q1.size() + q2.size()) > 0; k++) @(negedge clk);
        checkOutput("scoreboard empty", 64'(q0.size() + q1.size() + q2.size()), 64'(0));
    endtask

    // Output monitors: every o_valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (ov0 === 1'b1) begin
            checkOutput("dut0 pulse expected", 64'(q0.size() > 0), 64'(1));
            if (q0.size() > 0) begin
                e0 = q0.pop_front();
                checkOutput("dut0 chars", 64'(ch0), e0.chars);
                checkOutput("dut0 tag", 64'(otg0), 64'(e0.tag));
                checkOutput("dut0 overflow", 64'(of0), 64'(e0.ovf));
                checkOutput("dut0 latency", 64'(cyc), 64'(e0.cyc));
            end
        end
    end

    always @(negedge clk) begin
        if (ov1 === 1'b1) begin
            checkOutput("dut1 pulse expected", 64'(q1.size() > 0), 64'(1));
            if (q1.size() > 0) begin
                e1 = q1.pop_front();
                checkOutput("dut1 chars", 64'(ch1), e1.chars);
                checkOutput("dut1 tag", 64'(otg1), 64'(e1.tag));
                checkOutput("dut1 overflow", 64'(of1), 64'(e1.ovf));
                checkOutput("dut1 latency", 64'(cyc), 64'(e1.cyc));
            end
        end
    end

    always @(negedge clk) begin
        if (ov2 === 1'b1) begin
            checkOutput("dut2 pulse expected", 64'(q2.size() > 0), 64'(1));
            if (q2.size() > 0) begin
                e2 = q2.pop_front();
                checkOutput("dut2 chars", ch2, e2.chars);
                checkOutput("dut2 tag", 64'(otg2), 64'(e2.tag));
                checkOutput("dut2 overflow", 64'(of2), 64'(e2.ovf));
                checkOutput("dut2 latency", 64'(cyc), 64'(e2.cyc));
            end
        end
    end

    initial begin
        rst = 1'b1;
        driveInputs(0, 1'b0, 36'h0, 2'd0);
        driveInputs(1, 1'b0, 36'h0, 2'd0);
        driveInputs(2, 1'b0, 36'h0, 2'd0);
        repeat (2) @(negedge clk);
        checkOutput("reset ready", 64'(r0), 64'(1));
        checkOutput("reset valid", 64'(ov0), 64'(0));
        checkOutput("reset chars", 64'(ch0), 64'("       "));
        checkOutput("reset tag", 64'(otg0), 64'(0));
        checkOutput("reset overflow", 64'(of0), 64'(0));
        checkOutput("reset chars dut2", ch2, 64'("        "));
        rst = 1'b0;
        @(negedge clk);

        // Default Q3.30 instance: representative values and the most negative input.
        applyStimulus(0, 36'h0_2000_0000, 2'd1, 64'(" 0.5000"), 1'b0, 0, 1, acc);
        applyStimulus(0, 36'h1_B000_0000, 2'd2, 64'("-1.2500"), 1'b0, 0, 1, acc);
        applyStimulus(0, 36'h1_0000_0000, 2'd3, 64'("-4.0000"), 1'b0, 0, 1, acc);
        applyStimulus(0, 36'h0_3FFF_FFFF, 2'd0, 64'(" 0.9999"), 1'b0, 0, 1, acc);
        applyStimulus(0, 36'd763337568,   2'd1, 64'(" 0.7109"), 1'b0, 0, 1, acc);
        drain();
        repeat (3) @(negedge clk);
        checkOutput("hold chars", 64'(ch0), 64'(" 0.7109"));
        checkOutput("hold tag", 64'(otg0), 64'(1));

        // Q6.30 instances: overflow, lead blanking, negative zero display.
        applyStimulus(1, 36'h3_0000_0000, 2'd2, 64'(" #.####"), 1'b1, 0, 1, acc);
        applyStimulus(1, 36'hE_2000_0000, 2'd1, 64'("-7.5000"), 1'b0, 0, 1, acc);
        applyStimulus(2, 36'h0_C000_0000, 2'd1, 64'("  3.0000"), 1'b0, 0, 1, acc);
        applyStimulus(2, 36'hF_FFFF_D60F, 2'd2, 64'("- 0.0000"), 1'b0, 0, 1, acc);
        applyStimulus(2, 36'h8_0000_0000, 2'd3, 64'("-32.0000"), 1'b0, 0, 1, acc);
        drain();

        // Back-to-back with i_valid held: busy for N0 cycles, second accept in the first idle cycle.
        applyStimulus(0, 36'h0_2000_0000, 2'd2, 64'(" 0.5000"), 1'b0, 1, 1, accFirst);
        driveInputs(0, 1'b1, 36'h1_B000_0000, 2'd3);
        for (int k = 0; k < N0; k++) begin
            checkOutput("busy ready", 64'(r0), 64'(0));
            @(negedge clk);
        end
        checkOutput("idle ready", 64'(r0), 64'(1));
        applyStimulus(0, 36'h1_B000_0000, 2'd3, 64'("-1.2500"), 1'b0, 0, 1, acc);
        checkOutput("second accept cycle", 64'(acc - accFirst), 64'(N0 + 1));
        drain();

        // Reset in the middle of a conversion: no pulse, outputs back to reset values.
        applyStimulus(0, 36'h1_B000_0000, 2'd1, 64'("-1.2500"), 1'b0, 0, 0, acc);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("abort ready", 64'(r0), 64'(1));
        checkOutput("abort chars", 64'(ch0), 64'("       "));
        @(negedge clk);
        rst = 1'b0;
        repeat (2 * N0) @(negedge clk);
        checkOutput("post-reset ready", 64'(r0), 64'(1));
        checkOutput("post-reset chars", 64'(ch0), 64'("       "));
        checkOutput("post-reset tag", 64'(otg0), 64'(0));
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
